// File: rtl/count_pkg.sv
// Shared encodings for the syn_count_mod counter family.
package count_pkg;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/count_next.sv
// Combinational next-state for one counter step: next count/dir plus
// boundary (up/down limit hit) and turnaround (bounce reversal) flags.
module count_next
    import count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count_nxt,
    output logic             dir_nxt,
    output logic             boundary,
    output logic             turnaround
);

    localparam logic [WIDTH-1:0] W_ZERO = '0;
    localparam logic [WIDTH-1:0] W_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic w_at_top;
    logic w_at_bot;
    logic w_lim_zero;

    assign w_at_top   = (count >= limit);
    assign w_at_bot   = (count == W_ZERO);
    assign w_lim_zero = (limit == W_ZERO);

    // Step selection; a zero limit in bounce pins the count at 0 while dir flips.
    always_comb begin
        count_nxt  = count;
        dir_nxt    = dir;
        boundary   = 1'b0;
        turnaround = 1'b0;
        case (mode)
            MODE_UP: begin
                dir_nxt = DIR_UP;
                if (!w_at_top) begin
                    count_nxt = count + W_ONE;
                end else begin
                    boundary  = 1'b1;
                    count_nxt = sat ? limit : W_ZERO;
                end
            end
            MODE_DOWN: begin
                dir_nxt = DIR_DOWN;
                if (!w_at_bot) begin
                    count_nxt = count - W_ONE;
                end else begin
                    boundary  = 1'b1;
                    count_nxt = sat ? W_ZERO : limit;
                end
            end
            MODE_BOUNCE: begin
                if (dir == DIR_UP) begin
                    if (!w_at_top) begin
                        count_nxt = count + W_ONE;
                    end else begin
                        turnaround = 1'b1;
                        dir_nxt    = DIR_DOWN;
                        count_nxt  = w_lim_zero ? W_ZERO : (limit - W_ONE);
                    end
                end else begin
                    if (!w_at_bot) begin
                        count_nxt = count - W_ONE;
                    end else begin
                        turnaround = 1'b1;
                        dir_nxt    = DIR_UP;
                        count_nxt  = w_lim_zero ? W_ZERO : W_ONE;
                    end
                end
            end
            default: begin
                count_nxt = count;
                dir_nxt   = dir;
            end
        endcase
    end

endmodule

// File: rtl/syn_count_mod.sv
// Programmable-limit modulo counter: up/down/bounce, wrap or saturate,
// synchronous clamped load, registered tc pulse and sticky ovf flag.
module syn_count_mod
    import count_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sat,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_tc;
    logic             r_ovf;

    logic [WIDTH-1:0] w_count_nxt;
    logic             w_dir_nxt;
    logic             w_boundary;
    logic             w_turnaround;
    logic             w_step;
    logic [WIDTH-1:0] w_load_clamped;

    count_next #(.WIDTH(WIDTH)) u_count_next (
        .count      (r_count),
        .dir        (r_dir),
        .mode       (mode),
        .sat        (sat),
        .limit      (limit),
        .count_nxt  (w_count_nxt),
        .dir_nxt    (w_dir_nxt),
        .boundary   (w_boundary),
        .turnaround (w_turnaround)
    );

    assign w_step         = en && (mode != MODE_HOLD);
    assign w_load_clamped = (load_val > limit) ? limit : load_val;

    // Count/dir/tc registers: load outranks stepping; idle cycles drop tc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= RST_VAL;
            r_dir   <= DIR_UP;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_dir   <= DIR_UP;
            r_tc    <= 1'b0;
        end else if (w_step) begin
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_tc    <= w_boundary | w_turnaround;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    // Sticky overflow: a boundary hit on this edge beats a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (!load && w_step && w_boundary) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign count = r_count;
    assign dir   = r_dir;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_syn_count_mod.sv
// Directed bench for syn_count_mod (WIDTH=4, RST_VAL=0).
module tb_syn_count_mod;
    import count_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       sat;
    logic [3:0] limit;
    logic       load;
    logic [3:0] load_val;
    logic       clr_ovf;
    logic [3:0] count;
    logic       dir;
    logic       tc;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    syn_count_mod #(.WIDTH(4), .RST_VAL(4'd0)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .sat      (sat),
        .limit    (limit),
        .load     (load),
        .load_val (load_val),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .dir      (dir),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] c, input logic d,
                           input logic t, input logic o);
        chk({tag, ".count"}, {28'd0, count}, {28'd0, c});
        chk({tag, ".dir"},   {31'd0, dir},   {31'd0, d});
        chk({tag, ".tc"},    {31'd0, tc},    {31'd0, t});
        chk({tag, ".ovf"},   {31'd0, ovf},   {31'd0, o});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_HOLD; sat = 1'b0; limit = 4'd9;
        load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;
        #12;
        chk_all("reset", 4'd0, 1'b1, 1'b0, 1'b0);

        // Up, wrap, limit 9
        mode = MODE_UP; en = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk_all($sformatf("up%0d", k), k[3:0], 1'b1, 1'b0, 1'b0);
        end
        tick(); chk_all("up_wrap", 4'd0, 1'b1, 1'b1, 1'b1);
        tick(); chk_all("up_after", 4'd1, 1'b1, 1'b0, 1'b1);
        en = 1'b0; clr_ovf = 1'b1;
        tick(); chk_all("clr_ovf", 4'd1, 1'b1, 1'b0, 1'b0);
        clr_ovf = 1'b0;

        // Down, saturate, limit 5, from load 2
        limit = 4'd5; mode = MODE_DOWN; sat = 1'b1; en = 1'b1;
        load = 1'b1; load_val = 4'd2;
        tick(); chk_all("dn_load", 4'd2, 1'b1, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk_all("dn1", 4'd1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("dn0", 4'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("dn_sat", 4'd0, 1'b0, 1'b1, 1'b1);
        clr_ovf = 1'b1;
        tick(); chk_all("dn_sat_clr", 4'd0, 1'b0, 1'b1, 1'b1);
        en = 1'b0;
        tick(); chk_all("dn_clr", 4'd0, 1'b0, 1'b0, 1'b0);
        clr_ovf = 1'b0;

        // Bounce, limit 3
        limit = 4'd3; load = 1'b1; load_val = 4'd0; mode = MODE_BOUNCE;
        tick(); chk_all("bn_load", 4'd0, 1'b1, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); chk_all("bn1", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("bn2", 4'd2, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("bn3", 4'd3, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("bn_top", 4'd2, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("bn1d", 4'd1, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("bn0d", 4'd0, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("bn_bot", 4'd1, 1'b1, 1'b1, 1'b0);

        // Bounce with zero limit
        limit = 4'd0;
        tick(); chk_all("bnz1", 4'd0, 1'b0, 1'b1, 1'b0);
        tick(); chk_all("bnz2", 4'd0, 1'b1, 1'b1, 1'b0);

        // Hold mode with en high
        mode = MODE_HOLD;
        tick(); chk_all("hold", 4'd0, 1'b1, 1'b0, 1'b0);

        // Clamped load with en low
        en = 1'b0; limit = 4'd7; load = 1'b1; load_val = 4'd12;
        tick(); chk_all("ld_clamp", 4'd7, 1'b1, 1'b0, 1'b0);

        // Saturating up at the limit, then async reset mid-count
        load = 1'b0; mode = MODE_UP; sat = 1'b1; en = 1'b1;
        tick(); chk_all("up_sat", 4'd7, 1'b1, 1'b1, 1'b1);
        load = 1'b1; load_val = 4'd5;
        tick(); chk_all("ld5", 4'd5, 1'b1, 1'b0, 1'b1);
        load = 1'b0; sat = 1'b0;
        tick(); chk_all("up6", 4'd6, 1'b1, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 4'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); rst = 1'b0;
        tick(); chk_all("resume", 4'd1, 1'b1, 1'b0, 1'b0);

        // Limit lowered below current count while counting up
        limit = 4'd15; load = 1'b1; load_val = 4'd8;
        tick(); chk_all("ld8", 4'd8, 1'b1, 1'b0, 1'b0);
        load = 1'b0; limit = 4'd4;
        tick(); chk_all("lim_drop", 4'd0, 1'b1, 1'b1, 1'b1);

        // Down wrap to limit
        mode = MODE_DOWN;
        tick(); chk_all("dn_wrap", 4'd4, 1'b0, 1'b1, 1'b1);

        // Natural rollover with full-range limit
        limit = 4'd15; mode = MODE_UP; load = 1'b1; load_val = 4'd15;
        tick(); chk_all("ld15", 4'd15, 1'b1, 1'b0, 1'b1);
        load = 1'b0;
        tick(); chk_all("roll", 4'd0, 1'b1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout observed running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
